// File: rtl/alu_pkg.sv
// Shared encodings for the serial ALU: operation select and controller states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_XOR  = 2'b01,
    OP_AND  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_serial_if.sv
// Handshake and data bundle between the control sequencer and the serial ALU.
interface alu_serial_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             co;
  logic             v;
  logic             z;

  modport master (
    output start, a, b, sel, ci,
    input  busy, done, result, co, v, z
  );

  modport slave (
    input  start, a, b, sel, ci,
    output busy, done, result, co, v, z
  );

endinterface

// File: rtl/alu_slice2.sv
// Combinational 2-bit ALU slice; carries are only non-zero for ADD.
module alu_slice2
  import alu_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  op_e        i_sel,
  input  logic       i_ci,
  output logic [1:0] o_r,
  output logic       o_co,
  output logic       o_c1
);

  always_comb begin
    o_r  = '0;
    o_co = 1'b0;
    o_c1 = 1'b0;
    unique case (i_sel)
      OP_ADD: begin
        o_c1   = (i_a[0] & i_b[0]) | (i_ci & (i_a[0] ^ i_b[0]));
        o_r[0] = i_a[0] ^ i_b[0] ^ i_ci;
        o_r[1] = i_a[1] ^ i_b[1] ^ o_c1;
        o_co   = (i_a[1] & i_b[1]) | (o_c1 & (i_a[1] ^ i_b[1]));
      end
      OP_XOR:  o_r = i_a ^ i_b;
      OP_AND:  o_r = i_a & i_b;
      OP_PASS: o_r = i_a;
      default: o_r = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: walks a WIDTH-bit operand pair through one 2-bit slice,
// LSB slice first, with a start/busy/done handshake and registered flags.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  alu_serial_if.slave  bus
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  op_e              r_sel;
  logic             r_carry;
  logic             r_zacc;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_co;
  logic             r_v;
  logic             r_z;

  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W:0]   w_lsb;
  logic [1:0]       w_r2;
  logic             w_co2;
  logic             w_c12;

  // IDLE and DONE both accept a new request
  assign w_accept = (r_state != ST_RUN) && bus.start;
  assign w_last   = (r_cnt == CNT_W'(SLICES - 1));
  assign w_lsb    = {r_cnt, 1'b0};

  alu_slice2 u_slice (
    .i_a  (r_a[w_lsb +: 2]),
    .i_b  (r_b[w_lsb +: 2]),
    .i_sel(r_sel),
    .i_ci (r_carry),
    .o_r  (w_r2),
    .o_co (w_co2),
    .o_c1 (w_c12)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= OP_ADD;
      r_carry  <= 1'b0;
      r_zacc   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_co     <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_sel    <= op_e'(bus.sel);
      r_carry  <= (bus.sel == OP_ADD) ? bus.ci : 1'b0;
      r_cnt    <= '0;
      r_zacc   <= 1'b1;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_result[w_lsb +: 2] <= w_r2;
      r_carry              <= w_co2;
      r_zacc               <= r_zacc & (w_r2 == 2'b00);
      r_cnt                <= r_cnt + 1'b1;
      if (w_last) begin
        // slice carries are already zero for non-ADD ops
        r_cnt  <= '0;
        r_done <= 1'b1;
        r_co   <= w_co2;
        r_v    <= w_c12 ^ w_co2;
        r_z    <= r_zacc & (w_r2 == 2'b00);
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.co     = r_co;
  assign bus.v      = r_v;
  assign bus.z      = r_z;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: full-width arithmetic model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_alu_serial;

  localparam int WIDTH  = 8;
  localparam int SLICES = WIDTH / 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_serial_if #(.WIDTH(WIDTH)) bus ();

  alu_serial #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Behavioural model: latency countdown plus whole-word arithmetic
  logic             m_busy   = 1'b0;
  logic             m_done   = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic             m_co     = 1'b0;
  logic             m_v      = 1'b0;
  logic             m_z      = 1'b0;
  logic [WIDTH-1:0] p_result = '0;
  logic             p_co     = 1'b0;
  logic             p_v      = 1'b0;
  int               m_left   = 0;

  task automatic model_eval(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic [1:0] ts, input logic tc);
    logic [WIDTH:0] s;
    p_co = 1'b0;
    p_v  = 1'b0;
    case (ts)
      2'b00: begin
        s        = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
        p_result = s[WIDTH-1:0];
        p_co     = s[WIDTH];
        p_v      = (ta[WIDTH-1] == tb[WIDTH-1]) && (p_result[WIDTH-1] != ta[WIDTH-1]);
      end
      2'b01:   p_result = ta ^ tb;
      2'b10:   p_result = ta & tb;
      default: p_result = ta;
    endcase
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_result = '0;
      m_co = 1'b0; m_v = 1'b0; m_z = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_result = p_result; m_co = p_co; m_v = p_v; m_z = (p_result == '0);
      end
    end else if (bus.start) begin
      model_eval(bus.a, bus.b, bus.sel, bus.ci);
      m_result = '0;
      m_busy = 1'b1; m_done = 1'b0; m_left = SLICES;
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    #1;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    if (!m_busy) begin
      chk("result", 32'(bus.result), 32'(m_result));
      chk("co", 32'(bus.co), 32'(m_co));
      chk("v",  32'(bus.v),  32'(m_v));
      chk("z",  32'(bus.z),  32'(m_z));
    end
  end

  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic [1:0] ts, input logic tc);
    @(negedge clk);
    bus.a = ta; bus.b = tb; bus.sel = ts; bus.ci = tc; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt);
    int n;
    busy_cnt = 0;
    n = 0;
    #2;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      #2;
      n++;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic chk_out(string tag, logic [WIDTH-1:0] r, logic c, logic ov, logic zz);
    chk({tag, "_result"}, 32'(bus.result), 32'(r));
    chk({tag, "_co"}, 32'(bus.co), 32'(c));
    chk({tag, "_v"},  32'(bus.v),  32'(ov));
    chk({tag, "_z"},  32'(bus.z),  32'(zz));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int bc;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sel = 2'b00; bus.ci = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    start_op(8'h7F, 8'h01, 2'b00, 1'b0);
    wait_done(bc);
    chk("add1_busy_cycles", 32'(bc), 32'd4);
    chk_out("add1", 8'h80, 1'b0, 1'b1, 1'b0);

    start_op(8'hFF, 8'h00, 2'b00, 1'b1);
    wait_done(bc);
    chk("add2_busy_cycles", 32'(bc), 32'd4);
    chk_out("add2", 8'h00, 1'b1, 1'b0, 1'b1);
    @(negedge clk); #2;
    chk("add2_done_pulse", 32'(bus.done), 32'd0);

    start_op(8'hA5, 8'h5A, 2'b01, 1'b1);
    wait_done(bc);
    chk_out("xor", 8'hFF, 1'b0, 1'b0, 1'b0);

    start_op(8'hF0, 8'h0F, 2'b10, 1'b0);
    wait_done(bc);
    chk_out("and", 8'h00, 1'b0, 1'b0, 1'b1);

    start_op(8'h3C, 8'hFF, 2'b11, 1'b1);
    bus.a = 8'h00;
    wait_done(bc);
    chk_out("pass", 8'h3C, 1'b0, 1'b0, 1'b0);

    // start while busy is ignored; start in the done cycle is accepted
    start_op(8'h12, 8'h34, 2'b00, 1'b0);
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.sel = 2'b01; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(bc);
    chk_out("ign", 8'h46, 1'b0, 1'b0, 1'b0);
    bus.a = 8'h01; bus.b = 8'h02; bus.sel = 2'b01; bus.start = 1'b1;
    @(negedge clk); #2;
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_done", 32'(bus.done), 32'd0);
    wait_done(bc);
    chk_out("b2b", 8'h03, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a run
    start_op(8'h55, 8'h55, 2'b00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk_out("mrst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    start_op(8'h55, 8'h55, 2'b00, 1'b0);
    wait_done(bc);
    chk("post_busy_cycles", 32'(bc), 32'd4);
    chk_out("post", 8'hAA, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
